// File: rtl/fpga_msg_up_arbiter.sv
// Shares the 64-bit uplink between three sources, each with a one-entry slot, using round-robin grant and a paced handshake.
// Latency: a source strobe reaches up_vld_o 2 cycles later when the FSM is idle; GAP_CYCLES idle cycles follow each transfer.
// Backpressure: the message is held on up_data_o until up_rdy_i; sources never stall and a newer strobe overwrites, counting a drop.
module fpga_msg_up_arbiter #(
    parameter int GAP_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        src0_vld_i,
    input  logic [63:0] src0_data_i,
    input  logic        src1_vld_i,
    input  logic [63:0] src1_data_i,
    input  logic        src2_vld_i,
    input  logic [63:0] src2_data_i,
    output logic        up_vld_o,
    output logic [63:0] up_data_o,
    output logic [1:0]  up_src_o,
    input  logic        up_rdy_i,
    output logic [2:0]  pend_o,
    output logic [23:0] drop_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_t;

    typedef struct packed {
        logic [1:0]  src;
        logic [63:0] dat;
    } msg_t;

    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    logic [2:0]  src_vld;
    logic [63:0] src_dat [3];
    logic [63:0] slot_dat [3];
    logic [2:0]  pend;
    logic [7:0]  drop_cnt [3];
    logic [1:0]  last_grant;
    state_t      state;
    logic [7:0]  gap_cnt;
    msg_t        up_msg;
    logic        up_vld;

    logic [1:0]  win;
    logic [63:0] win_dat;
    logic        grant_en;
    logic [2:0]  grant_oh;

    assign src_vld    = {src2_vld_i, src1_vld_i, src0_vld_i};
    assign src_dat[0] = src0_data_i;
    assign src_dat[1] = src1_data_i;
    assign src_dat[2] = src2_data_i;

    // Round-robin: search begins at the slot after the last one granted.
    always_comb begin
        win = 2'd0;
        case (last_grant)
            2'd0:    win = pend[1] ? 2'd1 : (pend[2] ? 2'd2 : 2'd0);
            2'd1:    win = pend[2] ? 2'd2 : (pend[0] ? 2'd0 : 2'd1);
            default: win = pend[0] ? 2'd0 : (pend[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        win_dat = slot_dat[0];
        case (win)
            2'd1:    win_dat = slot_dat[1];
            2'd2:    win_dat = slot_dat[2];
            default: win_dat = slot_dat[0];
        endcase
    end

    assign grant_en = (state == ST_IDLE) && (|pend);
    assign grant_oh = grant_en ? (3'b001 << win) : 3'b000;

    // A strobe coinciding with its own grant refills the slot without a drop.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend <= '0;
            for (int n = 0; n < 3; n++) begin
                slot_dat[n] <= '0;
                drop_cnt[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 3; n++) begin
                if (src_vld[n]) begin
                    slot_dat[n] <= src_dat[n];
                    pend[n]     <= 1'b1;
                    if (pend[n] && !grant_oh[n] && (drop_cnt[n] != 8'hFF)) begin
                        drop_cnt[n] <= drop_cnt[n] + 8'd1;
                    end
                end else if (grant_oh[n]) begin
                    pend[n] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= ST_IDLE;
            gap_cnt    <= '0;
            last_grant <= 2'd2;
            up_vld     <= 1'b0;
            up_msg     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_en) begin
                        up_msg.src <= win;
                        up_msg.dat <= win_dat;
                        last_grant <= win;
                        up_vld     <= 1'b1;
                        state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (up_rdy_i) begin
                        up_vld  <= 1'b0;
                        gap_cnt <= '0;
                        state   <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign up_vld_o   = up_vld;
    assign up_data_o  = up_msg.dat;
    assign up_src_o   = up_msg.src;
    assign pend_o     = pend;
    assign drop_cnt_o = {drop_cnt[2], drop_cnt[1], drop_cnt[0]};

endmodule

// File: tb/tb_fpga_msg_up_arbiter.sv
// Directed bench for fpga_msg_up_arbiter: stimulus pushes expected uplink messages, a forked monitor pops and compares on each handshake.
module tb_fpga_msg_up_arbiter;

    localparam int GAP = 16;

    typedef struct packed {
        logic [1:0]  src;
        logic [63:0] dat;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        src0_vld_i, src1_vld_i, src2_vld_i;
    logic [63:0] src0_data_i, src1_data_i, src2_data_i;
    logic        up_vld_o;
    logic [63:0] up_data_o;
    logic [1:0]  up_src_o;
    logic        up_rdy_i;
    logic [2:0]  pend_o;
    logic [23:0] drop_cnt_o;

    fpga_msg_up_arbiter #(.GAP_CYCLES(GAP)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .src0_vld_i  (src0_vld_i),
        .src0_data_i (src0_data_i),
        .src1_vld_i  (src1_vld_i),
        .src1_data_i (src1_data_i),
        .src2_vld_i  (src2_vld_i),
        .src2_data_i (src2_data_i),
        .up_vld_o    (up_vld_o),
        .up_data_o   (up_data_o),
        .up_src_o    (up_src_o),
        .up_rdy_i    (up_rdy_i),
        .pend_o      (pend_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int          n_vec = 0;
    int          n_err = 0;
    exp_t        exp_q[$];
    bit          prev_stall;
    logic [63:0] prev_dat;
    bit          have_prev;
    int          prev_hs;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [1:0] src, input logic [63:0] dat);
        exp_t e;
        e.src = src;
        e.dat = dat;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_src();
        src0_vld_i = 1'b0;
        src1_vld_i = 1'b0;
        src2_vld_i = 1'b0;
    endtask

    task automatic do_reset();
        clear_src();
        rst_n_i = 1'b0;
        repeat (2) tick();
        rst_n_i = 1'b1;
        tick();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_n_i) begin
                prev_stall = 1'b0;
                have_prev  = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_vld", up_vld_o, 1);
                    chk("hold_data", up_data_o, prev_dat);
                end
                if (up_vld_o && up_rdy_i) begin
                    if (have_prev) chk("spacing_ok", ((cyc - prev_hs) >= GAP + 2), 1);
                    prev_hs   = cyc;
                    have_prev = 1'b1;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_msg: got src %0d data %0h, expected no message", up_src_o, up_data_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("up_src", up_src_o, e.src);
                        chk("up_data", up_data_o, e.dat);
                    end
                end
                prev_stall = up_vld_o && !up_rdy_i;
                prev_dat   = up_data_o;
            end
        end
    endtask

    task automatic burst();
        src0_vld_i = 1'b1; src0_data_i = 64'hA0;
        src1_vld_i = 1'b1; src1_data_i = 64'hA1;
        src2_vld_i = 1'b1; src2_data_i = 64'hA2;
        push(0, 64'hA0);
        push(1, 64'hA1);
        push(2, 64'hA2);
        tick();
        clear_src();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bit bad;
        rst_n_i = 1'b0;
        up_rdy_i = 1'b0;
        clear_src();
        src0_data_i = '0;
        src1_data_i = '0;
        src2_data_i = '0;
        prev_stall = 1'b0;
        have_prev = 1'b0;
        prev_hs = 0;
        prev_dat = '0;
        fork
            monitor();
        join_none

        repeat (3) tick();
        chk("rst_up_vld", up_vld_o, 0);
        chk("rst_up_data", up_data_o, 0);
        chk("rst_up_src", up_src_o, 0);
        chk("rst_pend", pend_o, 0);
        chk("rst_drop", drop_cnt_o, 0);
        rst_n_i = 1'b1;
        up_rdy_i = 1'b1;
        tick();

        // Single message latency and gap pacing
        src1_vld_i = 1'b1;
        src1_data_i = 64'h0000_0000_1234_5678;
        push(1, 64'h0000_0000_1234_5678);
        tick();
        src1_vld_i = 1'b0;
        chk("t1_pend", pend_o, 3'b010);
        chk("t1_vld_t1", up_vld_o, 0);
        tick();
        chk("t1_vld_t2", up_vld_o, 1);
        chk("t1_src_t2", up_src_o, 1);
        chk("t1_data_t2", up_data_o, 64'h0000_0000_1234_5678);
        tick();
        chk("t1_vld_k1", up_vld_o, 0);
        src0_vld_i = 1'b1;
        src0_data_i = 64'h0000_0000_00C0_FFEE;
        push(0, 64'h0000_0000_00C0_FFEE);
        tick();
        src0_vld_i = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < GAP; i++) begin
            if (up_vld_o) bad = 1'b1;
            tick();
        end
        chk("t1_gap_quiet", bad, 0);
        chk("t1_next_vld", up_vld_o, 1);
        drain(100);

        // Simultaneous burst, round-robin order
        do_reset();
        burst();
        drain(200);
        chk("t2_pend_a", pend_o, 0);
        burst();
        drain(200);
        chk("t2_pend_b", pend_o, 0);

        // Stalled output with overwrite on src0
        do_reset();
        up_rdy_i = 1'b0;
        src0_vld_i = 1'b1;
        src0_data_i = 64'hD0D0_D0D0_D0D0_D0D0;
        push(0, 64'hD0D0_D0D0_D0D0_D0D0);
        tick();
        clear_src();
        tick();
        chk("t3_vld", up_vld_o, 1);
        src0_vld_i = 1'b1;
        src0_data_i = 64'hD1D1_D1D1_D1D1_D1D1;
        tick();
        src0_data_i = 64'hD2D2_D2D2_D2D2_D2D2;
        push(0, 64'hD2D2_D2D2_D2D2_D2D2);
        tick();
        clear_src();
        repeat (50) tick();
        chk("t3_held_data", up_data_o, 64'hD0D0_D0D0_D0D0_D0D0);
        chk("t3_drop", drop_cnt_o, 24'h000001);
        chk("t3_pend", pend_o, 3'b001);
        up_rdy_i = 1'b1;
        drain(100);

        // Drop counter saturation on src2
        do_reset();
        up_rdy_i = 1'b0;
        src0_vld_i = 1'b1;
        src0_data_i = 64'h5555_0000_0000_5555;
        push(0, 64'h5555_0000_0000_5555);
        tick();
        clear_src();
        tick();
        for (int i = 0; i < 300; i++) begin
            src2_vld_i = 1'b1;
            src2_data_i = 64'(i);
            tick();
        end
        clear_src();
        chk("t4_drop_sat", drop_cnt_o, 24'hFF0000);
        chk("t4_pend", pend_o, 3'b100);
        push(2, 64'd299);
        up_rdy_i = 1'b1;
        drain(100);

        // Grant and new strobe on the same slot in the same cycle
        do_reset();
        up_rdy_i = 1'b1;
        src1_vld_i = 1'b1;
        src1_data_i = 64'h0123_4567_89AB_CDEF;
        push(1, 64'h0123_4567_89AB_CDEF);
        tick();
        src1_data_i = 64'hFEDC_BA98_7654_3210;
        push(1, 64'hFEDC_BA98_7654_3210);
        tick();
        clear_src();
        chk("t5_pend", pend_o, 3'b010);
        chk("t5_drop", drop_cnt_o, 0);
        chk("t5_old_out", up_data_o, 64'h0123_4567_89AB_CDEF);
        drain(100);
        chk("t5_drop_end", drop_cnt_o, 0);

        // Asynchronous reset while a message is held and two slots are pending
        do_reset();
        up_rdy_i = 1'b0;
        src0_vld_i = 1'b1;
        src0_data_i = 64'h7777_7777_7777_7777;
        tick();
        clear_src();
        tick();
        src1_vld_i = 1'b1;
        src1_data_i = 64'h1111;
        src2_vld_i = 1'b1;
        src2_data_i = 64'h2222;
        tick();
        clear_src();
        chk("t6_pre_vld", up_vld_o, 1);
        chk("t6_pre_pend", pend_o, 3'b110);
        rst_n_i = 1'b0;
        #1;
        chk("t6_rst_vld", up_vld_o, 0);
        chk("t6_rst_data", up_data_o, 0);
        chk("t6_rst_src", up_src_o, 0);
        chk("t6_rst_pend", pend_o, 0);
        chk("t6_rst_drop", drop_cnt_o, 0);
        tick();
        tick();
        rst_n_i = 1'b1;
        up_rdy_i = 1'b1;
        bad = 1'b0;
        repeat (40) begin
            if (up_vld_o) bad = 1'b1;
            tick();
        end
        chk("t6_quiet", bad, 0);
        src2_vld_i = 1'b1;
        src2_data_i = 64'hBEEF_0000_0000_BEEF;
        push(2, 64'hBEEF_0000_0000_BEEF);
        tick();
        clear_src();
        drain(100);

        repeat (4) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
